vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: VRAM word address width.
REQ-002 Parameter DATA_W, default 9: VRAM word width, packed {red[2:0], green[2:0], blue[2:0]}.
REQ-003 Parameter STARVE_MAX, default 4: consecutive CPU-lost cycles before CPU is forced a slot.
REQ-004 clk_in  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 vga_req  in  1  scan-out pixel fetch request.
REQ-007 vga_addr  in  ADDR_W  scan-out fetch address.
REQ-008 vga_blank  in  1  high during horizontal/vertical blanking.
REQ-009 vga_gnt  out  1  VGA request accepted this cycle.
REQ-010 vga_rvalid  out  1  vga_rdata valid, one-cycle pulse.
REQ-011 vga_rdata  out  DATA_W  fetched pixel word.
REQ-012 cpu_req  in  1  CPU access request.
REQ-013 cpu_we  in  1  1 = write, 0 = read.
REQ-014 cpu_addr  in  ADDR_W  CPU address.
REQ-015 cpu_wdata  in  DATA_W  CPU write data.
REQ-016 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-017 cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
REQ-018 cpu_rdata  out  DATA_W  CPU read data.
REQ-019 ram_en, ram_we  out  1 each  single-port VRAM enable / write enable.
REQ-020 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W  VRAM address / write data.
REQ-021 ram_rdata  in  DATA_W  VRAM read data, valid one cycle after ram_en with ram_we=0.
REQ-022 vga_miss_cnt  out  16  count of cycles VGA was denied by the starvation override.

Function
REQ-023 Grant combinational per cycle; at most one of vga_gnt/cpu_gnt high; a request is consumed in its grant cycle.
REQ-024 Only one requester: that requester granted.
REQ-025 Both requesting: CPU granted if vga_blank=1 or starve_cnt==STARVE_MAX; otherwise VGA.
REQ-026 Requesters hold req/addr/we/wdata stable until granted; arbiter does not buffer requests.
REQ-027 Granted cycle: ram_en=1, ram_addr/ram_wdata/ram_we from winner (ram_we=0 for VGA); no grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-028 starve_cnt: +1 when cpu_req=1 and cpu_gnt=0, saturate at STARVE_MAX; cleared when cpu_gnt=1 or cpu_req=0.
REQ-029 Read owner tracked in 2-stage registered pipeline {NONE, VGA, CPU}; CPU writes enter as NONE.
REQ-030 Read granted cycle N: ram_rdata registered at edge ending N+1; owner's rdata/rvalid presented in N+2; total latency 2 cycles.
REQ-031 Back-to-back reads every cycle sustained, one rvalid per read, order preserved.
REQ-032 rdata holds last value when rvalid=0; non-owner rvalid stays 0.
REQ-033 vga_miss_cnt +1 per cycle with vga_req=1, cpu_gnt=1 and vga_blank=0; saturates at 16'hFFFF.

Reset
REQ-034 rst=1 forces gnts 0, ram_en 0, both rvalids 0, rdata 0, starve_cnt 0, vga_miss_cnt 0, pipeline NONE.
REQ-035 Reads granted before or during rst cycle never produce rvalid; normal arbitration first cycle after rst falls.

Structure
REQ-036 Package vram_pkg holds ADDR_W/DATA_W/STARVE_MAX defaults and owner enum {OWN_NONE, OWN_VGA, OWN_CPU}.
REQ-037 One sub-module vram_rd_pipe implements the owner/data return pipeline; arbitration and counters stay in vram_arbiter.

Verification
REQ-038 CPU write addr 0x0010 data 0x1FF, no VGA -> cpu_gnt same cycle, ram_en=1 ram_we=1, no rvalid.
REQ-039 Continuous vga_req, vga_blank=0, cpu_req held -> VGA granted 4 cycles, CPU granted 5th, vga_miss_cnt=1.
REQ-040 Both request with vga_blank=1 -> cpu_gnt immediately, vga_gnt next cycle.
REQ-041 VGA reads addr 0..7 back-to-back, RAM model data=addr -> 8 vga_rvalid pulses 2 cycles after each grant, data 0..7 in order.
REQ-042 CPU read granted, rst pulsed next cycle -> cpu_rvalid never asserts, all outputs reset values.
REQ-043 Force vga_miss_cnt to 0xFFFF, trigger another miss -> count remains 0xFFFF.

Source files
------------

// File: rtl/vram_pkg.sv
// VRAM arbiter shared definitions.
// Default geometry and the read-owner tag carried down the return pipe.
package vram_pkg;

    localparam int ADDR_W_DEF     = 13;
    localparam int DATA_W_DEF     = 9;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: tags each granted read with its owner and
// steers the registered RAM data to that owner two cycles later.
module vram_rd_pipe
    import vram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  owner_e            issue_own,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);

    owner_e            own_s1;
    owner_e            own_s2;
    logic [DATA_W-1:0] vga_q;
    logic [DATA_W-1:0] cpu_q;

    // RAM data is valid while own_s1 is live; capture it into the owner's holder.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            own_s1 <= OWN_NONE;
            own_s2 <= OWN_NONE;
            vga_q  <= '0;
            cpu_q  <= '0;
        end else begin
            own_s1 <= issue_own;
            own_s2 <= own_s1;
            if (own_s1 == OWN_VGA) vga_q <= ram_rdata;
            if (own_s1 == OWN_CPU) cpu_q <= ram_rdata;
        end
    end

    assign vga_rvalid = !rst && (own_s2 == OWN_VGA);
    assign cpu_rvalid = !rst && (own_s2 == OWN_CPU);
    assign vga_rdata  = rst ? '0 : vga_q;
    assign cpu_rdata  = rst ? '0 : cpu_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between VGA scan-out and CPU, with a
// starvation override for the CPU and a count of VGA slots it cost.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_blank,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       vga_miss_cnt
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic [15:0]   miss_q;
    owner_e        issue_own;

    always_comb begin
        cpu_gnt   = 1'b0;
        vga_gnt   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        issue_own = OWN_NONE;
        cpu_gnt = !rst && cpu_req &&
                  (!vga_req || vga_blank || starve_cnt == SMAX);
        vga_gnt = !rst && vga_req && !cpu_gnt;
        if (cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_we ? cpu_wdata : '0;
            issue_own = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (vga_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = vga_addr;
            issue_own = OWN_VGA;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            starve_cnt <= '0;
            miss_q     <= '0;
        end else begin
            if (cpu_req && !cpu_gnt) begin
                if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            // Only an override steals a live scan-out slot.
            if (vga_req && cpu_gnt && !vga_blank && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign vga_miss_cnt = miss_q;

    vram_rd_pipe #(
        .DATA_W(DATA_W)
    ) u_rd_pipe (
        .clk_in    (clk_in),
        .rst       (rst),
        .issue_own (issue_own),
        .ram_rdata (ram_rdata),
        .vga_rvalid(vga_rvalid),
        .vga_rdata (vga_rdata),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus held-request random
// traffic, scored against a queue-based model of grants and read returns.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW = 13;
    localparam int DW = 9;
    localparam int SM = 4;

    logic          clk_in = 1'b0;
    logic          rst, vga_req, vga_blank, cpu_req, cpu_we;
    logic [AW-1:0] vga_addr, cpu_addr, ram_addr;
    logic [DW-1:0] cpu_wdata, ram_wdata, ram_rdata;
    logic [DW-1:0] vga_rdata, cpu_rdata;
    logic          vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid;
    logic          ram_en, ram_we;
    logic [15:0]   vga_miss_cnt;

    int vectors = 0;
    int errs    = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          mem_init;

    typedef struct {
        int            due;
        int            own;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          q[$];
    int            m_starve, m_miss, cyc;
    logic [DW-1:0] m_vdata, m_cdata;
    bit            m_vgnt, m_cgnt;
    logic          o_vg, o_cg, o_en, o_we;
    int            vpulses, cpulses;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_blank(vga_blank),
        .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .vga_miss_cnt(vga_miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous single-port RAM, preloaded with data = address.
    always @(posedge clk_in) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check mid-cycle against the model, then advance it.
    task automatic cycle();
        bit            ev, ec;
        logic [31:0]   ea, ed;
        #4;
        m_cgnt = !rst && cpu_req &&
                 (!vga_req || vga_blank || m_starve == SM);
        m_vgnt = !rst && vga_req && !m_cgnt;
        ev = 0;
        ec = 0;
        if (rst) begin
            m_vdata = '0;
            m_cdata = '0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].own == 1) begin ev = 1; m_vdata = q[0].data; end
            else               begin ec = 1; m_cdata = q[0].data; end
            q.delete(0);
        end
        ea = m_vgnt ? 32'(vga_addr) : m_cgnt ? 32'(cpu_addr) : 32'd0;
        ed = (m_cgnt && cpu_we) ? 32'(cpu_wdata) : 32'd0;
        o_vg = vga_gnt; o_cg = cpu_gnt; o_en = ram_en; o_we = ram_we;
        chk("vga_gnt", 32'(vga_gnt), 32'(m_vgnt));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cgnt));
        chk("ram_en", 32'(ram_en), 32'(m_vgnt | m_cgnt));
        chk("ram_we", 32'(ram_we), 32'(m_cgnt && cpu_we));
        chk("ram_addr", 32'(ram_addr), ea);
        chk("ram_wdata", 32'(ram_wdata), ed);
        chk("vga_rvalid", 32'(vga_rvalid), 32'(ev));
        chk("vga_rdata", 32'(vga_rdata), 32'(m_vdata));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cdata));
        chk("miss_cnt", 32'(vga_miss_cnt), 32'(m_miss));
        vpulses += int'(vga_rvalid === 1'b1);
        cpulses += int'(cpu_rvalid === 1'b1);
        if (rst) begin
            q.delete();
            m_starve = 0;
            m_miss   = 0;
        end else begin
            if (m_vgnt) q.push_back('{cyc + 2, 1, ref_mem[vga_addr]});
            if (m_cgnt && !cpu_we) q.push_back('{cyc + 2, 2, ref_mem[cpu_addr]});
            if (m_cgnt && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            if (vga_req && m_cgnt && !vga_blank && m_miss < 65535) m_miss++;
            if (cpu_req && !m_cgnt) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            else                    m_starve = 0;
        end
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    task automatic idle(int n);
        vga_req = 0;
        cpu_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int nv, p0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
        m_starve = 0; m_miss = 0; cyc = 0;
        m_vdata = '0; m_cdata = '0;
        vpulses = 0; cpulses = 0;
        rst = 1; mem_init = 1;
        vga_req = 0; vga_addr = '0; vga_blank = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        @(posedge clk_in);
        #1;
        mem_init = 0;
        // Requests during reset must be ignored.
        vga_req = 1; cpu_req = 1;
        cycle();
        cycle();
        rst = 0;
        idle(2);

        // CPU write with no VGA traffic.
        cpu_req = 1; cpu_we = 1; cpu_addr = AW'(16); cpu_wdata = 9'h1FF;
        cycle();
        chk("wr_gnt", 32'(o_cg), 32'd1);
        chk("wr_ram_en", 32'(o_en), 32'd1);
        chk("wr_ram_we", 32'(o_we), 32'd1);
        idle(3);

        // Starvation override against live scan-out.
        nv = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(5); vga_blank = 0;
        for (int i = 0; i < 10; i++) begin
            vga_req = 1; vga_addr = AW'(100 + i);
            cycle();
            if (o_cg === 1'b1) break;
            nv += int'(o_vg === 1'b1);
        end
        chk("starve_vga_slots", 32'(nv), 32'd4);
        chk("starve_miss", 32'(vga_miss_cnt), 32'd1);
        idle(3);

        // Blanking hands the slot to the CPU first.
        vga_req = 1; vga_addr = AW'(7); vga_blank = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(9);
        cycle();
        chk("blank_cpu_first", 32'(o_cg), 32'd1);
        cpu_req = 0;
        cycle();
        chk("blank_vga_next", 32'(o_vg), 32'd1);
        vga_blank = 0;
        idle(3);

        // Back-to-back scan-out reads 0..7.
        p0 = vpulses;
        for (int i = 0; i < 8; i++) begin
            vga_req = 1; vga_addr = AW'(i);
            cycle();
        end
        idle(3);
        chk("b2b_pulses", 32'(vpulses - p0), 32'd8);
        chk("b2b_last", 32'(vga_rdata), 32'd7);

        // Reset right after a CPU read kills its return.
        p0 = cpulses;
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(3);
        cycle();
        cpu_req = 0; rst = 1;
        cycle();
        rst = 0;
        idle(4);
        chk("rst_kill_rvalid", 32'(cpulses - p0), 32'd0);

        // Held-request random traffic.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!vga_req) begin
                vga_req  = 1'($urandom_range(0, 1));
                vga_addr = AW'($urandom_range(0, 31));
            end
            if (!cpu_req) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, 31));
                cpu_wdata = DW'($urandom);
            end
            vga_blank = ($urandom_range(0, 3) == 0);
            cycle();
            if (m_vgnt) vga_req = 0;
            if (m_cgnt) cpu_req = 0;
        end
        rst = 0; vga_blank = 0;
        idle(3);

        // Miss counter saturation.
        force dut.miss_q = 16'hFFFF;
        m_miss = 65535;
        cycle();
        release dut.miss_q;
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'(1);
        for (int i = 0; i < 10; i++) begin
            vga_req = 1; vga_addr = AW'(i);
            cycle();
            if (o_cg === 1'b1) break;
        end
        chk("miss_saturate", 32'(vga_miss_cnt), 32'hFFFF);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
